// File: rtl/alu_cmd_sequencer.sv
// Command FIFO, issue FSM and response register wrapped around an 8-bit arithmetic unit.
// Optional status outputs (res_zero, op_count) are enabled by defining ALU_SEQ_STATUS_EN.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [3:0] cmd_sel,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_out,
   input  logic       alu_carry,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic       res_carry,
`ifdef ALU_SEQ_STATUS_EN
   output logic       res_zero,
   output logic [15:0] op_count,
`endif
   output logic       res_err
);

   typedef enum logic [1:0] {IDLE, EXEC, DIVZ, RESP} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t      state, state_nxt;
   logic [19:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic        push, pop, head_divz, issue;
   logic [7:0]  head_a, head_b;
   logic [3:0]  head_sel;

   assign cmd_ready = (count != FULL_CNT);
   assign push      = cmd_valid && cmd_ready;
   assign {head_a, head_b, head_sel} = mem[rd_ptr];
   assign head_divz = (head_sel == 4'b0011) && (head_b == 8'h00);
   assign res_valid = (state == RESP);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: if (count != '0) begin
            pop = 1'b1;
            if (head_divz) begin
               state_nxt = DIVZ;
            end else begin
               issue     = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         DIVZ:    state_nxt = RESP;
         RESP:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Storage array carries no reset; validity is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (!push && pop) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         if (issue) begin
            alu_a   <= head_a;
            alu_b   <= head_b;
            alu_sel <= head_sel;
         end
         if (state == EXEC) begin
            res_data  <= alu_out;
            res_carry <= ((alu_sel == 4'd0) || alu_sel[3]) ? alu_carry : 1'b0;
            res_err   <= 1'b0;
         end else if (state == DIVZ) begin
            res_data  <= 8'hFF;
            res_carry <= 1'b0;
            res_err   <= 1'b1;
         end
      end
   end

`ifdef ALU_SEQ_STATUS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_zero <= 1'b0;
         op_count <= '0;
      end else begin
         if (state == EXEC)      res_zero <= (alu_out == 8'h00);
         else if (state == DIVZ) res_zero <= 1'b0;
         if (state == RESP && res_ready) op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural arithmetic unit stub.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_a = '0, cmd_b = '0;
   logic [3:0] cmd_sel = '0;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [3:0] alu_sel;
   logic       alu_carry;
   logic       res_valid, res_ready = 1'b0;
   logic [7:0] res_data;
   logic       res_carry, res_err;
`ifdef ALU_SEQ_STATUS_EN
   logic       res_zero;
   logic [15:0] op_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_carry(res_carry),
`ifdef ALU_SEQ_STATUS_EN
      .res_zero(res_zero), .op_count(op_count),
`endif
      .res_err(res_err)
   );

   // Arithmetic unit stub: shifts are by one, sel 8..15 behave as add.
   logic [8:0] sum;
   always_comb begin
      sum       = {1'b0, alu_a} + {1'b0, alu_b};
      alu_carry = sum[8];
      case (alu_sel)
         4'd1:    alu_out = alu_a - alu_b;
         4'd2:    alu_out = alu_a * alu_b;
         4'd3:    alu_out = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
         4'd4:    alu_out = alu_a << 1;
         4'd5:    alu_out = alu_a >> 1;
         4'd6:    alu_out = alu_a & alu_b;
         4'd7:    alu_out = alu_a | alu_b;
         default: alu_out = sum[7:0];
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
      int waited = 0;
      cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
      while (!cmd_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!cmd_ready) begin
         check_eq("push_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic get_resp(input string tag, input logic [7:0] data, input logic carry, input logic err);
      int waited = 0;
      while (!res_valid && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!res_valid) begin
         check_eq({tag, "_timeout"}, 32'(res_valid), 32'd1);
         return;
      end
      check_eq({tag, "_data"},  32'(res_data),  32'(data));
      check_eq({tag, "_carry"}, 32'(res_carry), 32'(carry));
      check_eq({tag, "_err"},   32'(res_err),   32'(err));
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   initial begin
      int seen;
      #12;
      check_eq("rst_res_valid", 32'(res_valid), 32'd0);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_alu_a",     32'(alu_a),     32'd0);
      check_eq("rst_res_data",  32'(res_data),  32'd0);
      check_eq("rst_res_err",   32'(res_err),   32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: push at edge N, response valid after N+2
      res_ready = 1'b1;
      push(8'hF0, 8'h20, 4'd0);
      check_eq("lat_n0", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_n1", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_n2", 32'(res_valid), 32'd1);
      get_resp("add", 8'h10, 1'b1, 1'b0);

      push(8'd100, 8'd0, 4'd3);
      get_resp("divz", 8'hFF, 1'b0, 1'b1);
      check_eq("divz_alu_a",   32'(alu_a),   32'hF0);
      check_eq("divz_alu_b",   32'(alu_b),   32'h20);
      check_eq("divz_alu_sel", 32'(alu_sel), 32'd0);

      push(8'h0C, 8'h03, 4'd2);
      push(8'h81, 8'h00, 4'd4);
      get_resp("mul", 8'h24, 1'b0, 1'b0);
      get_resp("shl", 8'h02, 1'b0, 1'b0);

      // Backpressure: five pushes with res_ready low, one issued, four queued
      res_ready = 1'b0;
      push(8'h01, 8'h02, 4'd0);
      push(8'h90, 8'h80, 4'd1);
      push(8'hF0, 8'h0F, 4'd7);
      push(8'h3C, 8'h0F, 4'd6);
      push(8'hFF, 8'h01, 4'd8);
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("bp_res_valid", 32'(res_valid), 32'd1);
      get_resp("bp0_add", 8'h03, 1'b0, 1'b0);
      get_resp("bp1_sub", 8'h10, 1'b0, 1'b0);
      get_resp("bp2_or",  8'hFF, 1'b0, 1'b0);
      get_resp("bp3_and", 8'h0C, 1'b0, 1'b0);
      get_resp("bp4_sel8", 8'h00, 1'b1, 1'b0);

      // Reset while in RESP with two entries queued
      push(8'h11, 8'h22, 4'd0);
      push(8'h01, 8'h01, 4'd0);
      push(8'h02, 8'h02, 4'd0);
      check_eq("mr_in_resp", 32'(res_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mr_res_valid", 32'(res_valid), 32'd0);
      check_eq("mr_res_data",  32'(res_data),  32'd0);
      check_eq("mr_alu_a",     32'(alu_a),     32'd0);
      check_eq("mr_cmd_ready", 32'(cmd_ready), 32'd1);
      #2 rst_n = 1'b1;
      res_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (res_valid) seen++;
      end
      check_eq("mr_no_resp", 32'(seen), 32'd0);
      res_ready = 1'b0;

`ifdef ALU_SEQ_STATUS_EN
      check_eq("st_cnt_rst", 32'(op_count), 32'd0);
      push(8'h55, 8'hAA, 4'd6);
      wait_valid: for (int i = 0; i < 10 && !res_valid; i++) begin
         @(posedge clk); #1;
      end
      check_eq("st_zero", 32'(res_zero), 32'd1);
      get_resp("st_and", 8'h00, 1'b0, 1'b0);
      check_eq("st_cnt", 32'(op_count), 32'd1);
      push(8'h00, 8'h00, 4'd3);
      get_resp("st_divz", 8'hFF, 1'b0, 1'b1);
      check_eq("st_zero_divz", 32'(res_zero), 32'd0);
      check_eq("st_cnt2", 32'(op_count), 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end and result back-end wrapped around the 8-bit combinational arithmetic unit (add, sub, mul, div, shl, shr, and, or).
- Buffers incoming operation requests in a small FIFO and presents registered operands and select to the unit.
- Captures the unit's result and carry one cycle later and returns them on a valid/ready response channel.
- Detects divide-by-zero before issue and never drives the unit with a zero divisor.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, min 2).
- AW, 2, FIFO pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  FIFO can accept this cycle.
- cmd_a  input  8  operand a.
- cmd_b  input  8  operand b.
- cmd_sel  input  4  operation code, same encoding as the arithmetic unit.
- alu_a  output  8  registered operand a to the unit.
- alu_b  output  8  registered operand b to the unit.
- alu_sel  output  4  registered select to the unit.
- alu_out  input  8  unit result.
- alu_carry  input  1  unit carry (carry of a+b).
- res_valid  output  1  response present.
- res_ready  input  1  consumer accepts response.
- res_data  output  8  result.
- res_carry  output  1  carry, qualified as defined under Behaviour.
- res_err  output  1  divide-by-zero flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, FSM in IDLE.
  - alu_a, alu_b, alu_sel, res_data, res_carry, res_err, res_valid all 0.
- cmd_ready = !full, combinational from registered count only; no same-cycle pop bypass. When full, a push is refused even if a pop happens in the same cycle.
- Push on cmd_valid && cmd_ready. Push and pop may occur in the same cycle; count is unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the operand regs.
    - If sel==4'b0011 and b==0, go to DIVZ; alu_* are not updated.
    - Otherwise go to EXEC.
  - EXEC: one settle cycle. At the clock edge, capture res_data=alu_out and res_carry=(alu_sel==0 || alu_sel>=8) ? alu_carry : 0. Set res_err=0 and go to RESP.
  - DIVZ: set res_data=8'hFF, res_carry=0, res_err=1, and go to RESP.
  - RESP: res_valid=1; res_data, res_carry and res_err are held stable. On res_valid && res_ready, clear res_valid and go to IDLE.
- Latency:
  - Command pushed at edge N into an empty FIFO with the FSM idle: res_valid rises after edge N+2.
  - Minimum throughput is one operation per 3 cycles (IDLE, EXEC, RESP) with res_ready held high.
- sel 4'b1000..4'b1111 pass through to the unit, which treats them as add; carry is reported and res_err=0.
- alu_a, alu_b and alu_sel hold their last issued values outside EXEC.
- Backpressure: while in RESP the FIFO keeps filling until full. Commands are never dropped, and responses come out in command order.
- Reset mid-operation aborts the in-flight operation and flushes the FIFO; no response is produced for it.

Optional Feature:
- Macro: ALU_SEQ_STATUS_EN.
- Defined:
  - Adds output res_zero (1): registered with res_data, high when the captured result is 8'h00. It is forced to 0 on DIVZ.
  - Adds output op_count (16): counts completed response handshakes, wraps at 16'hFFFF to 0, and resets to 0.
- Undefined: neither port exists and no related logic is present.

Test Plan:
- Push {a=8'h F0, b=8'h20, sel=0} with res_ready=1 -> res_valid after 2 edges; res_data=8'h10, res_carry=1, res_err=0.
- Push {a=8'd100, b=8'd0, sel=3} -> alu_* unchanged from the prior op; res_data=8'hFF, res_err=1, res_carry=0.
- Push {a=8'h0C, b=8'h03, sel=2}, then {a=8'h81, b=8'h00, sel=4} -> responses in order: 8'h24 carry 0, then 8'h02 carry 0.
- Hold res_ready=0 and push 5 commands back-to-back (DEPTH=4):
  - 1 is popped and the FIFO fills to 4, so cmd_ready drops.
  - Release res_ready -> all 5 responses return in order, none lost.
- Assert rst_n low while the FSM is in RESP with the FIFO holding 2 entries:
  - All outputs go to 0 immediately and cmd_ready=1.
  - No response appears after rst_n returns high.
- With ALU_SEQ_STATUS_EN defined, push {a=8'h55, b=8'hAA, sel=6} -> res_data=8'h00, res_zero=1, op_count increments by 1 on handshake.
